ps2_hack_keyboard: RTL and testbench

//  Receives PS/2 set-2 scancodes from an external keyboard on two io pins and turns them into
//  a Hack keycode. Drives the 8-bit keycode input of hack_soc, upstream of the keyboard memory map.

---
 rtl/hack_ps2_pkg.sv | 29 ++
 rtl/ps2_scancode_to_hack.sv | 46 ++++
 rtl/ps2_hack_keyboard.sv | 246 ++++++++++++++++++++++++
 tb/tb_ps2_hack_keyboard.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_ps2_pkg.sv
// Shared definitions for the PS/2 -> Hack keyboard path: frame FSM states,
// Set-2 prefix bytes, Hack special-key codes and the odd-parity helper.
package hack_ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    localparam logic [7:0] HACK_SPACE     = 8'd32;
    localparam logic [7:0] HACK_NEWLINE   = 8'd128;
    localparam logic [7:0] HACK_BACKSPACE = 8'd129;
    localparam logic [7:0] HACK_LEFT      = 8'd130;
    localparam logic [7:0] HACK_UP        = 8'd131;
    localparam logic [7:0] HACK_RIGHT     = 8'd132;
    localparam logic [7:0] HACK_DOWN      = 8'd133;
    localparam logic [7:0] HACK_ESC       = 8'd140;

    // True when the data byte plus its parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_scancode_to_hack.sv
// Combinational Set-2 scancode -> Hack keycode translation.
// Letters map to uppercase only; anything not listed yields 0.
import hack_ps2_pkg::*;

module ps2_scancode_to_hack (
    input  logic       ext,
    input  logic [7:0] scancode,
    output logic [7:0] hack
);

    // Table lookup; extended codes only carry the four arrow keys.
    always_comb begin
        hack = 8'd0;
        if (ext) begin
            case (scancode)
                8'h6B:   hack = HACK_LEFT;
                8'h75:   hack = HACK_UP;
                8'h74:   hack = HACK_RIGHT;
                8'h72:   hack = HACK_DOWN;
                default: hack = 8'd0;
            endcase
        end else begin
            case (scancode)
                8'h1C: hack = 8'd65;  8'h32: hack = 8'd66;  8'h21: hack = 8'd67;
                8'h23: hack = 8'd68;  8'h24: hack = 8'd69;  8'h2B: hack = 8'd70;
                8'h34: hack = 8'd71;  8'h33: hack = 8'd72;  8'h43: hack = 8'd73;
                8'h3B: hack = 8'd74;  8'h42: hack = 8'd75;  8'h4B: hack = 8'd76;
                8'h3A: hack = 8'd77;  8'h31: hack = 8'd78;  8'h44: hack = 8'd79;
                8'h4D: hack = 8'd80;  8'h15: hack = 8'd81;  8'h2D: hack = 8'd82;
                8'h1B: hack = 8'd83;  8'h2C: hack = 8'd84;  8'h3C: hack = 8'd85;
                8'h2A: hack = 8'd86;  8'h1D: hack = 8'd87;  8'h22: hack = 8'd88;
                8'h35: hack = 8'd89;  8'h1A: hack = 8'd90;
                8'h45: hack = 8'd48;  8'h16: hack = 8'd49;  8'h1E: hack = 8'd50;
                8'h26: hack = 8'd51;  8'h25: hack = 8'd52;  8'h2E: hack = 8'd53;
                8'h36: hack = 8'd54;  8'h3D: hack = 8'd55;  8'h3E: hack = 8'd56;
                8'h46: hack = 8'd57;
                8'h29: hack = HACK_SPACE;
                8'h5A: hack = HACK_NEWLINE;
                8'h66: hack = HACK_BACKSPACE;
                8'h76: hack = HACK_ESC;
                default: hack = 8'd0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_hack_keyboard.sv
// PS/2 Set-2 keyboard receiver producing the Hack keycode of the held key.
// Pipeline: 2-FF synchronisers -> ps2_clk glitch filter -> frame FSM with
// timeout -> prefix/byte handler -> keycode register.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
import hack_ps2_pkg::*;

module ps2_hack_keyboard #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic             clk_meta_r, clk_sync_r;
    logic             data_meta_r, data_sync_r;
    logic             clk_filt_r;
    logic [FLT_W-1:0] flt_cnt_r;
    logic             strobe_s;

    ps2_state_e       state_r, state_nxt_s;
    logic [7:0]       shift_r, shift_nxt_s;
    logic [2:0]       bit_cnt_r, bit_cnt_nxt_s;
    logic [TO_W-1:0]  to_cnt_r;
    logic             timeout_s;
    logic             accept_s, err_s, parity_ok_s;
    logic [7:0]       byte_r;
    logic             byte_ready_r;

    logic             ext_r, brk_r;
    logic [7:0]       lookup_s;
    logic [7:0]       keycode_r;
    logic             key_valid_r, frame_err_r;

`ifdef PS2_PARITY_CHECK_EN
    logic             par_r, par_nxt_s;
`endif

    // Two-stage synchronisers for both pad inputs; idle bus level is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Glitch filter: adopt a new ps2_clk level after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_filt_r <= 1'b1;
            flt_cnt_r  <= '0;
        end else if (clk_sync_r != clk_filt_r) begin
            if (flt_cnt_r == FLT_W'(FILTER_LEN - 1)) begin
                clk_filt_r <= clk_sync_r;
                flt_cnt_r  <= '0;
            end else begin
                flt_cnt_r  <= flt_cnt_r + FLT_W'(1);
            end
        end else begin
            flt_cnt_r <= '0;
        end
    end

    // Sample strobe: the cycle in which the filtered level is about to fall.
    assign strobe_s = clk_filt_r & ~clk_sync_r & (flt_cnt_r == FLT_W'(FILTER_LEN - 1));

    // A frame in progress that sees no strobe for TIMEOUT_CYCLES cycles is abandoned.
    assign timeout_s = (state_r != IDLE) && !strobe_s &&
                       (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok_s = odd_parity_ok(shift_r, par_r);
`else
    assign parity_ok_s = 1'b1;
`endif

    // Frame FSM next-state and datapath logic, advanced only by strobes or timeout.
    always_comb begin
        state_nxt_s   = state_r;
        shift_nxt_s   = shift_r;
        bit_cnt_nxt_s = bit_cnt_r;
        accept_s      = 1'b0;
        err_s         = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_nxt_s     = par_r;
`endif
        if (timeout_s) begin
            state_nxt_s   = IDLE;
            shift_nxt_s   = 8'h00;
            bit_cnt_nxt_s = 3'd0;
            err_s         = 1'b1;
        end else if (strobe_s) begin
            case (state_r)
                IDLE: begin
                    if (!data_sync_r) begin
                        state_nxt_s   = DATA;
                        shift_nxt_s   = 8'h00;
                        bit_cnt_nxt_s = 3'd0;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                DATA: begin
                    shift_nxt_s   = {data_sync_r, shift_r[7:1]};
                    bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_nxt_s = PARITY;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_nxt_s   = data_sync_r;
`endif
                    state_nxt_s = STOP;
                end
                STOP: begin
                    state_nxt_s = IDLE;
                    if (data_sync_r && parity_ok_s) begin
                        accept_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Frame FSM state and datapath registers; accepted bytes are handed on one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            shift_r      <= 8'h00;
            bit_cnt_r    <= 3'd0;
            byte_r       <= 8'h00;
            byte_ready_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            shift_r      <= shift_nxt_s;
            bit_cnt_r    <= bit_cnt_nxt_s;
            byte_ready_r <= accept_s;
            frame_err_r  <= err_s;
            if (accept_s) begin
                byte_r <= shift_r;
            end else begin
                byte_r <= byte_r;
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    // Latched parity bit of the frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_r <= 1'b0;
        end else begin
            par_r <= par_nxt_s;
        end
    end
`endif

    // Inter-strobe watchdog: cleared by strobes and while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_r <= '0;
        end else if (strobe_s || (state_r == IDLE) || timeout_s) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end
    end

    ps2_scancode_to_hack u_lut (
        .ext      (ext_r),
        .scancode (byte_r),
        .hack     (lookup_s)
    );

    // Byte handler: track E0/F0 prefixes and update the held keycode on make/break.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_r       <= 1'b0;
            brk_r       <= 1'b0;
            keycode_r   <= 8'h00;
            key_valid_r <= 1'b0;
        end else begin
            key_valid_r <= 1'b0;
            if (timeout_s) begin
                ext_r <= 1'b0;
                brk_r <= 1'b0;
            end else if (byte_ready_r) begin
                if (byte_r == PREFIX_EXT) begin
                    ext_r <= 1'b1;
                end else if (byte_r == PREFIX_BRK) begin
                    brk_r <= 1'b1;
                end else begin
                    ext_r <= 1'b0;
                    brk_r <= 1'b0;
                    if (brk_r) begin
                        if ((lookup_s == keycode_r) && (keycode_r != 8'h00)) begin
                            keycode_r   <= 8'h00;
                            key_valid_r <= 1'b1;
                        end else begin
                            keycode_r   <= keycode_r;
                        end
                    end else if ((lookup_s != 8'h00) && (lookup_s != keycode_r)) begin
                        keycode_r   <= lookup_s;
                        key_valid_r <= 1'b1;
                    end else begin
                        keycode_r   <= keycode_r;
                    end
                end
            end else begin
                ext_r <= ext_r;
                brk_r <= brk_r;
            end
        end
    end

    assign keycode   = keycode_r;
    assign key_valid = key_valid_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_hack_keyboard.sv
// Self-checking bench for ps2_hack_keyboard: a directed vector table, randomized
// scancode traffic against a keyboard model, and hand-written timeout/reset sequences.
module tb_ps2_hack_keyboard;

    localparam int HALF = 12;
    localparam int TO   = 2000;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       key_valid;
    logic       frame_err;

    int vectors     = 0;
    int miscompares = 0;
    int kv_count    = 0;
    int fe_count    = 0;

    ps2_hack_keyboard #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keycode   (keycode),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Count output pulses away from the active edge.
    always @(negedge clk) begin
        if (!reset && key_valid) kv_count = kv_count + 1;
        if (!reset && frame_err) fe_count = fe_count + 1;
    end

    // ---------------- reference keyboard model ----------------
    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                      8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                      8'h3D, 8'h3E, 8'h46};
    logic [7:0] arrow_codes [4]   = '{8'h6B, 8'h75, 8'h74, 8'h72};
    logic [7:0] misc_codes  [4]   = '{8'h29, 8'h5A, 8'h66, 8'h76};
    int         misc_hack   [4]   = '{32, 128, 129, 140};

    int m_key = 0;
    bit m_ext = 1'b0;
    bit m_brk = 1'b0;

    function automatic int model_lookup(input bit ext, input logic [7:0] c);
        int r;
        r = 0;
        if (ext) begin
            for (int i = 0; i < 4; i++) if (arrow_codes[i] == c) r = 130 + i;
        end else begin
            for (int i = 0; i < 26; i++) if (letter_codes[i] == c) r = 65 + i;
            for (int i = 0; i < 10; i++) if (digit_codes[i] == c) r = 48 + i;
            for (int i = 0; i < 4; i++)  if (misc_codes[i] == c)  r = misc_hack[i];
        end
        return r;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int lk;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            lk = model_lookup(m_ext, b);
            if (m_brk) begin
                if (lk == m_key) m_key = 0;
            end else if (lk != 0) begin
                m_key = lk;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act != exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one PS/2 device frame (first nbits bits); optional short ps2_clk glitches.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit glitch);
        logic [10:0] bits;
        int g;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (glitch) begin
                g = (i % 3) + 1;
                repeat (3) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (g) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (HALF - 3 - g) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic run_frame(input string name, input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input bit glitch,
                             input int exp_key, input int exp_kv, input int exp_fe);
        int kv0, fe0;
        kv0 = kv_count;
        fe0 = fe_count;
        send_frame(b, bad_par, bad_stop, 11, glitch);
        repeat (10) @(negedge clk);
        check({name, ".keycode"},   int'(keycode), exp_key);
        check({name, ".key_valid"}, kv_count - kv0, exp_kv);
        check({name, ".frame_err"}, fe_count - fe0, exp_fe);
    endtask

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        bit         bad_stop;
        bit         glitch;
        int         exp_key;
        int         exp_kv;
        int         exp_fe;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int kv0, fe0, old_key, r, lk;
        logic [7:0] code;
        bit bstop, glt;

        tbl[0]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 65,  1, 0};
        tbl[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 65,  0, 0};
        tbl[2]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 0,   1, 0};
        tbl[3]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 65,  1, 0};
        tbl[4]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 65,  0, 0};
        tbl[5]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 65,  0, 0};
        tbl[6]  = '{8'h32, 1'b0, 1'b0, 1'b0, 65,  0, 0};
        tbl[7]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 65,  0, 0};
        tbl[8]  = '{8'h75, 1'b0, 1'b0, 1'b0, 131, 1, 0};
        tbl[9]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 131, 0, 0};
        tbl[10] = '{8'hF0, 1'b0, 1'b0, 1'b0, 131, 0, 0};
        tbl[11] = '{8'h75, 1'b0, 1'b0, 1'b0, 0,   1, 0};
        tbl[12] = '{8'h07, 1'b0, 1'b0, 1'b0, 0,   0, 0};
        tbl[13] = '{8'h1C, 1'b0, 1'b1, 1'b0, 0,   0, 1};
`ifdef PS2_PARITY_CHECK_EN
        tbl[14] = '{8'h1C, 1'b1, 1'b0, 1'b0, 0,   0, 1};
`else
        tbl[14] = '{8'h1C, 1'b1, 1'b0, 1'b0, 65,  1, 0};
`endif
        tbl[15] = '{8'h16, 1'b0, 1'b0, 1'b1, 49,  1, 0};

        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check("reset.keycode",   int'(keycode),   0);
        check("reset.key_valid", int'(key_valid), 0);
        check("reset.frame_err", int'(frame_err), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 16; i++) begin
            run_frame($sformatf("tbl%0d", i), tbl[i].code, tbl[i].bad_par, tbl[i].bad_stop,
                      tbl[i].glitch, tbl[i].exp_key, tbl[i].exp_kv, tbl[i].exp_fe);
            if (!tbl[i].bad_stop && (!tbl[i].bad_par || !PAR_EN)) model_byte(tbl[i].code);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 1)      code = 8'hF0;
            else if (r == 2) code = 8'hE0;
            else if (r == 3) code = arrow_codes[$urandom_range(0, 3)];
            else if (r <= 5) code = letter_codes[$urandom_range(0, 25)];
            else if (r == 6) code = digit_codes[$urandom_range(0, 9)];
            else if (r == 7) code = misc_codes[$urandom_range(0, 3)];
            else             code = 8'($urandom_range(0, 255));
            bstop = ($urandom_range(0, 15) == 0);
            glt   = ($urandom_range(0, 3) == 0);
            old_key = m_key;
            if (!bstop) model_byte(code);
            run_frame($sformatf("rnd%0d", n), code, 1'b0, bstop, glt,
                      m_key, (m_key != old_key) ? 1 : 0, bstop ? 1 : 0);
        end

        // Timeout: E0 prefix, then a frame that stalls after 4 data bits.
        run_frame("to.pre", 8'hE0, 1'b0, 1'b0, 1'b0, m_key, 0, 0);
        model_byte(8'hE0);
        old_key = m_key;
        fe0 = fe_count;
        send_frame(8'h5A, 1'b0, 1'b0, 5, 1'b0);
        repeat (TO + 100) @(negedge clk);
        check("timeout.frame_err", fe_count - fe0, 1);
        check("timeout.keycode", int'(keycode), old_key);
        m_ext = 1'b0;
        m_brk = 1'b0;
        run_frame("after_to", 8'h5A, 1'b0, 1'b0, 1'b0, 128, (old_key != 128) ? 1 : 0, 0);
        m_key = 128;

        // Reset mid-frame while 'A' is held.
        run_frame("rst.pre", 8'h1C, 1'b0, 1'b0, 1'b0, 65, 1, 0);
        send_frame(8'h33, 1'b0, 1'b0, 4, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst.keycode",   int'(keycode),   0);
        check("midrst.key_valid", int'(key_valid), 0);
        check("midrst.frame_err", int'(frame_err), 0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        m_key = 0; m_ext = 1'b0; m_brk = 1'b0;
        run_frame("postrst", 8'h16, 1'b0, 1'b0, 1'b0, 49, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
